seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Handshaked, parametrised ALU sitting between register read and writeback.
// Single-cycle ops (logic, add/sub, compares, shifts) produce a registered
// result one cycle after accept. MUL (shift-add) and DIVU (restoring) run
// one bit per cycle and complete WIDTH+1 cycles after accept. At most one
// op is in flight; the issuer is stalled via in_ready while the unit is busy
// or holding an unconsumed result.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   in_valid   A, B, ALUCtl valid this cycle
//   in_ready   unit can accept an op (high only in IDLE)
//   A, B       operands (shift amount is B[SHW-1:0])
//   ALUCtl     operation code
//   out_valid  ALUOut/HI/Zero/Overflow valid (high only in DONE)
//   out_ready  consumer takes the result
//   ALUOut     primary result
//   HI         MUL high word / DIVU remainder, 0 for other ops
//   Zero       ALUOut == 0
//   Overflow   signed overflow for ADD/SUB, 0 otherwise
// ---------------------------------------------------------------------------
module seq_alu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUCtl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUOut,
   output logic [WIDTH-1:0] HI,
   output logic             Zero,
   output logic             Overflow
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_MUL  = 4'b1001;
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_XOR  = 4'b1101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       ctl_q, ctl_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] work_hi_q, work_hi_d;
   logic [WIDTH-1:0] work_lo_q, work_lo_d;
   logic [WIDTH-1:0] alu_out_q, alu_out_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] sc_out;
   logic             sc_ovf;
   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] sub_res;
   logic [SHW-1:0]   shamt;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign ALUOut    = alu_out_q;
   assign HI        = hi_q;
   assign Zero      = zero_q;
   assign Overflow  = ovf_q;

   // Single-cycle result straight from the live inputs; it is only captured
   // on the accept edge, so using A/B here equals using the latched copies.
   always_comb begin
      sc_out  = '0;
      sc_ovf  = 1'b0;
      add_res = A + B;
      sub_res = A - B;
      shamt   = B[SHW-1:0];
      case (ALUCtl)
         OP_AND:  sc_out = A & B;
         OP_OR:   sc_out = A | B;
         OP_NOR:  sc_out = ~(A | B);
         OP_XOR:  sc_out = A ^ B;
         OP_ADD: begin
            sc_out = add_res;
            sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_out = sub_res;
            sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: sc_out = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLL:  sc_out = A << shamt;
         OP_SRL:  sc_out = A >> shamt;
         OP_SRA:  sc_out = $unsigned($signed(A) >>> shamt);
         default: sc_out = '0;
      endcase
   end

   // One iteration of the multi-cycle datapath. {work_hi, work_lo} is the
   // running product for MUL (multiplier bits consumed from work_lo[0]) and
   // {remainder, dividend/quotient} for DIVU. The remainder is always below
   // the divisor, so WIDTH bits plus the shifted-in bit are enough; the top
   // bit of the trial subtraction is the borrow. Division by zero naturally
   // yields an all-ones quotient and a remainder equal to A.
   always_comb begin
      mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_q};
      step_hi   = '0;
      step_lo   = '0;
      if (ctl_q == OP_MUL) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
      end else if (!div_trial[WIDTH]) begin
         step_hi = div_trial[WIDTH-1:0];
         step_lo = {work_lo_q[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = div_shift[WIDTH-1:0];
         step_lo = {work_lo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state and result-register logic for the IDLE/BUSY/DONE handshake.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      ctl_d     = ctl_q;
      cnt_d     = cnt_q;
      work_hi_d = work_hi_q;
      work_lo_d = work_lo_q;
      alu_out_d = alu_out_q;
      hi_d      = hi_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d   = A;
               b_d   = B;
               ctl_d = ALUCtl;
               if (ALUCtl == OP_MUL || ALUCtl == OP_DIVU) begin
                  cnt_d     = SHW'(WIDTH - 1);
                  work_hi_d = '0;
                  work_lo_d = (ALUCtl == OP_MUL) ? B : A;
                  state_d   = BUSY;
               end else begin
                  alu_out_d = sc_out;
                  hi_d      = '0;
                  zero_d    = (sc_out == '0);
                  ovf_d     = sc_ovf;
                  state_d   = DONE;
               end
            end
         end
         BUSY: begin
            work_hi_d = step_hi;
            work_lo_d = step_lo;
            cnt_d     = cnt_q - SHW'(1);
            if (cnt_q == '0) begin
               alu_out_d = step_lo;
               hi_d      = step_hi;
               zero_d    = (step_lo == '0);
               ovf_d     = 1'b0;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any op in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         ctl_q     <= '0;
         cnt_q     <= '0;
         work_hi_q <= '0;
         work_lo_q <= '0;
         alu_out_q <= '0;
         hi_q      <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         ctl_q     <= ctl_d;
         cnt_q     <= cnt_d;
         work_hi_q <= work_hi_d;
         work_lo_q <= work_lo_d;
         alu_out_q <= alu_out_d;
         hi_q      <= hi_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Directed testbench for seq_alu (WIDTH=32). Each scenario task drives its
// own stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_seq_alu;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALUCtl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUOut;
   logic [31:0] HI;
   logic        Zero;
   logic        Overflow;

   int total = 0;
   int bad   = 0;

   seq_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALUCtl    (ALUCtl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUOut    (ALUOut),
      .HI        (HI),
      .Zero      (Zero),
      .Overflow  (Overflow)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Present one op for a single cycle (caller is 1 time unit past an edge
   // and the unit is IDLE), then wait up to 100 cycles for out_valid.
   // lat counts cycles from the accept cycle to the first out_valid cycle.
   task automatic issue_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
      ALUCtl   = ctl;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      A        = 32'hDEAD_BEEF;
      B        = 32'h1234_5678;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Consume the pending result.
   task automatic pop_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      ALUCtl    = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if ({ALUOut, HI, Zero, Overflow} !== 66'd0) begin bad++; $display("[TB] FAIL reset_outputs got ALUOut=%h HI=%h Z=%b V=%b want all 0", ALUOut, HI, Zero, Overflow); end
   endtask

   task automatic test_add_overflow();
      int lat;
      issue_op(4'b0010, 32'h7FFF_FFFF, 32'h1, lat);
      total++; if (lat !== 1) begin bad++; $display("[TB] FAIL add_latency got=%0d want=1", lat); end
      total++; if (ALUOut !== 32'h8000_0000) begin bad++; $display("[TB] FAIL add_result got=%h want=80000000", ALUOut); end
      total++; if ({Overflow, Zero} !== 2'b10) begin bad++; $display("[TB] FAIL add_flags got V=%b Z=%b want V=1 Z=0", Overflow, Zero); end
      pop_result();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL add_pop got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      issue_op(4'b0110, 32'h8000_0000, 32'h1, lat);
      total++; if ({ALUOut, Overflow} !== {32'h7FFF_FFFF, 1'b1}) begin bad++; $display("[TB] FAIL sub_overflow got=%h V=%b want 7fffffff V=1", ALUOut, Overflow); end
      pop_result();
   endtask

   task automatic test_sub_backpressure();
      int lat;
      issue_op(4'b0110, 32'd5, 32'd5, lat);
      for (int i = 0; i < 3; i++) begin
         total++; if ({out_valid, in_ready, ALUOut, Zero, Overflow} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
            bad++; $display("[TB] FAIL sub_hold cycle %0d got ov=%b ir=%b out=%h Z=%b V=%b want 1 0 0 1 0", i, out_valid, in_ready, ALUOut, Zero, Overflow);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL sub_ready_early got=%b want=0", in_ready); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("[TB] FAIL sub_release got ir=%b ov=%b want 1 0", in_ready, out_valid); end
      total++; if ({ALUOut, Zero} !== {32'd0, 1'b1}) begin bad++; $display("[TB] FAIL idle_hold got=%h Z=%b want 0 Z=1", ALUOut, Zero); end
   endtask

   task automatic test_compare_shift();
      int lat;
      logic [3:0]  ctl_v [8] = '{4'b0111, 4'b1000, 4'b0101, 4'b0100, 4'b0011, 4'b1101, 4'b1100, 4'b0001};
      logic [31:0] a_v   [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'hF0, 32'h0, 32'hF0};
      logic [31:0] b_v   [8] = '{32'h1, 32'h1, 32'd4, 32'd4, 32'd31, 32'h3C, 32'h0, 32'h0F};
      logic [31:0] exp_v [8] = '{32'h1, 32'h0, 32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'hCC, 32'hFFFF_FFFF, 32'hFF};
      for (int i = 0; i < 8; i++) begin
         issue_op(ctl_v[i], a_v[i], b_v[i], lat);
         total++; if ({ALUOut, Zero, HI} !== {exp_v[i], (exp_v[i] == 32'd0), 32'd0}) begin
            bad++; $display("[TB] FAIL op_%b got=%h Z=%b HI=%h want=%h", ctl_v[i], ALUOut, Zero, HI, exp_v[i]);
         end
         pop_result();
      end
   endtask

   task automatic test_mul();
      int lat;
      int busy_ready_bad;
      busy_ready_bad = 0;
      ALUCtl   = 4'b1001;
      A        = 32'hFFFF_FFFF;
      B        = 32'h2;
      in_valid = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      // Keep poking with an ADD during BUSY; it must be ignored.
      while (!out_valid && lat < 100) begin
         if (in_ready !== 1'b0) busy_ready_bad++;
         in_valid = lat[0];
         ALUCtl   = 4'b0010;
         A        = 32'h1;
         B        = 32'h1;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      total++; if (lat !== 33) begin bad++; $display("[TB] FAIL mul_latency got=%0d want=33", lat); end
      total++; if (busy_ready_bad !== 0) begin bad++; $display("[TB] FAIL mul_busy_in_ready got=%0d high cycles want=0", busy_ready_bad); end
      total++; if ({ALUOut, HI, Zero, Overflow} !== {32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0}) begin
         bad++; $display("[TB] FAIL mul_result got=%h HI=%h Z=%b V=%b want fffffffe HI=1", ALUOut, HI, Zero, Overflow);
      end
      pop_result();
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mul_no_extra_op got in_ready=%b want=1", in_ready); end
   endtask

   task automatic test_divu();
      int lat;
      issue_op(4'b1010, 32'd100, 32'd7, lat);
      total++; if (lat !== 33) begin bad++; $display("[TB] FAIL divu_latency got=%0d want=33", lat); end
      total++; if ({ALUOut, HI} !== {32'd14, 32'd2}) begin bad++; $display("[TB] FAIL divu_result got=%0d HI=%0d want 14 HI=2", ALUOut, HI); end
      pop_result();
      issue_op(4'b1010, 32'd9, 32'd0, lat);
      total++; if (lat !== 33) begin bad++; $display("[TB] FAIL divz_latency got=%0d want=33", lat); end
      total++; if ({ALUOut, HI, Zero} !== {32'hFFFF_FFFF, 32'd9, 1'b0}) begin bad++; $display("[TB] FAIL divz_result got=%h HI=%h Z=%b want ffffffff HI=9", ALUOut, HI, Zero); end
      pop_result();
      issue_op(4'b1010, 32'd3, 32'd5, lat);
      total++; if ({ALUOut, HI, Zero} !== {32'd0, 32'd3, 1'b1}) begin bad++; $display("[TB] FAIL divu_zero_q got=%h HI=%h Z=%b want 0 HI=3 Z=1", ALUOut, HI, Zero); end
      pop_result();
      issue_op(4'b0001, 32'h5, 32'h0, lat);
      total++; if ({ALUOut, HI} !== {32'h5, 32'd0}) begin bad++; $display("[TB] FAIL hi_clear got=%h HI=%h want 5 HI=0", ALUOut, HI); end
      pop_result();
   endtask

   task automatic test_reset_abort();
      int lat;
      // Leave a nonzero result behind so the abort clearing is visible.
      issue_op(4'b1100, 32'h0, 32'h0, lat);
      pop_result();
      ALUCtl   = 4'b1001;
      A        = 32'h1234;
      B        = 32'h5678;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("[TB] FAIL abort_handshake got ir=%b ov=%b want 1 0", in_ready, out_valid); end
      total++; if ({ALUOut, HI, Zero, Overflow} !== 66'd0) begin bad++; $display("[TB] FAIL abort_outputs got=%h HI=%h Z=%b V=%b want all 0", ALUOut, HI, Zero, Overflow); end
      @(posedge clk); #2;
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("[TB] FAIL abort_stays_idle got ir=%b ov=%b want 1 0", in_ready, out_valid); end
      issue_op(4'b0000, 32'hF0, 32'h3C, lat);
      total++; if ({lat, ALUOut, Zero} !== {32'd1, 32'h30, 1'b0}) begin bad++; $display("[TB] FAIL and_after_abort got lat=%0d out=%h Z=%b want 1 30 0", lat, ALUOut, Zero); end
      pop_result();
      issue_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      total++; if ({lat, ALUOut, HI, Zero, Overflow} !== {32'd1, 32'd0, 32'd0, 1'b1, 1'b0}) begin
         bad++; $display("[TB] FAIL undefined_op got lat=%0d out=%h HI=%h Z=%b V=%b want 1 0 0 1 0", lat, ALUOut, HI, Zero, Overflow);
      end
      pop_result();
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_add_overflow();
      test_sub_backpressure();
      test_compare_shift();
      test_mul();
      test_divu();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
